// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and constants for the time-multiplexed FIR sequencer.
package fir_mac_sequencer_pkg;

  localparam int NTAPS_DEF = 8;
  localparam int DW_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  // Full-precision accumulator: product width plus headroom for NTAPS sums.
  function automatic int acc_width(input int dw, input int ntaps);
    return 2 * dw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac.sv
// Single signed multiplier feeding a clearable, enabled accumulator.
// sum is the combinational next value, so the caller can capture the
// final tap's result on the same edge that commits it.
module fir_mac_sequencer_mac
  import fir_mac_sequencer_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = acc_width(DW_DEF, NTAPS_DEF)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] sum
);

  logic signed [ACCW-1:0] acc;
  logic signed [2*DW-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + ACCW'(prod);

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR filter sequencer: one MAC walks NTAPS taps per sample.
// Optional macro FIR_MAC_SEQUENCER_SATURATE_EN clamps the output instead
// of wrapping it to DW bits.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter  int NTAPS = NTAPS_DEF,
  parameter  int DW    = DW_DEF,
  localparam int AW    = $clog2(NTAPS)
)(
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [DW-1:0] coef_data,
  input  logic                 flush,
  output logic                 busy
);

  localparam int ACCW = acc_width(DW, NTAPS);

  state_t state, nxt;

  logic signed [DW-1:0]   coef  [NTAPS];
  logic signed [DW-1:0]   dline [NTAPS];
  logic [AW-1:0]          wr_ptr, k, rd_idx;
  logic                   last_tap, accept, mac_clr, mac_en;
  logic signed [ACCW-1:0] sum, shifted;
  logic signed [DW-1:0]   result;

  // Newest sample sits at wr_ptr; tap k reads k samples back, modulo NTAPS.
  assign rd_idx   = (wr_ptr >= k) ? wr_ptr - k : wr_ptr - k + AW'(NTAPS);
  assign last_tap = (k == AW'(NTAPS - 1));
  assign shifted  = sum >>> (DW - 1);

`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
  logic fits;
  // In range only when every bit above the DW-bit sign bit matches it.
  assign fits   = (shifted[ACCW-1:DW-1] == {(ACCW-DW+1){shifted[ACCW-1]}});
  assign result = fits ? shifted[DW-1:0]
                : shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}}
                                  : {1'b0, {(DW-1){1'b1}}};
`else
  logic [ACCW-DW-1:0] unused_hi;
  assign unused_hi = shifted[ACCW-1:DW];
  assign result    = shifted[DW-1:0];
`endif

  fir_mac_sequencer_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk (system1000),
    .rst (system1000_rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (coef[k]),
    .b   (dline[rd_idx]),
    .sum (sum)
  );

  assign out_valid = (state == S_OUT);

  // State register.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) state <= S_IDLE;
    else                state <= nxt;
  end

  // Next state and handshake; config writes and flush block acceptance.
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    accept   = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = !coef_we && !flush;
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          nxt     = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (last_tap) nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Coefficients, delay line, tap/write pointers and the output register.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      wr_ptr   <= '0;
      k        <= '0;
      out_data <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        coef[i]  <= '0;
        dline[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (coef_we && (32'(coef_addr) < NTAPS)) coef[coef_addr] <= coef_data;
          if (flush) begin
            wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) dline[i] <= '0;
          end
          if (accept) begin
            dline[wr_ptr] <= in_data;
            k             <= '0;
          end
        end
        S_MAC: begin
          k <= last_tap ? '0 : k + 1'b1;
          if (last_tap) begin
            out_data <= result;
            wr_ptr   <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: a reference FIR computes each expected output when the
// sample is accepted; a monitor pops and compares on every output handshake.
module tb_fir_mac_sequencer;

  localparam int NTAPS = 8;
  localparam int DW    = 16;

  logic                 system1000 = 1'b0;
  logic                 system1000_rst = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 coef_we = 1'b0;
  logic [2:0]           coef_addr = '0;
  logic signed [DW-1:0] coef_data = '0;
  logic                 flush = 1'b0;
  logic                 busy;

  fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW)) dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .coef_we        (coef_we),
    .coef_addr      (coef_addr),
    .coef_data      (coef_data),
    .flush          (flush),
    .busy           (busy)
  );

  always #5 system1000 = ~system1000;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int last_acc = 0;

  logic signed [15:0] m_coef [NTAPS];
  logic signed [15:0] m_hist [NTAPS];
  int                 m_wr = 0;
  logic [15:0]        exp_q [$];

  always @(posedge system1000) cyc_cnt++;

  // Reference FIR: y = sum coef[k] * x[n-k], shifted by DW-1, then wrapped or clamped.
  function automatic logic [15:0] model_out();
    longint acc = 0;
    longint sh;
    for (int k = 0; k < NTAPS; k++)
      acc += longint'(m_coef[k]) * longint'(m_hist[(m_wr - k + NTAPS) % NTAPS]);
    sh = acc >>> 15;
`ifdef FIR_MAC_SEQUENCER_SATURATE_EN
    if (sh > 32767)  sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      m_coef[i] = '0;
      m_hist[i] = '0;
    end
    m_wr = 0;
    exp_q.delete();
  endtask

  // Output monitor: compares on every cycle where the handshake completes.
  always @(negedge system1000) begin
    if (!system1000_rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h with nothing expected", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge system1000);
    #1;
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_data = data;
    step();
    coef_we = 1'b0;
    m_coef[addr] = data;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < NTAPS; i++) m_hist[i] = '0;
    m_wr = 0;
  endtask

  task automatic send(input logic [15:0] s);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = s;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge system1000);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose for sample %h", s);
      in_valid = 1'b0;
      return;
    end
    step();
    last_acc = cyc_cnt;
    in_valid = 1'b0;
    m_hist[m_wr] = s;
    exp_q.push_back(model_out());
    m_wr = (m_wr + 1) % NTAPS;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
  endtask

  task automatic load_ramp_coefs();
    for (int k = 0; k < NTAPS; k++) write_coef(k, 16'(32'h1000 * (k + 1)));
  endtask

  task automatic test_reset();
    system1000_rst = 1'b1;
    repeat (2) step();
    system1000_rst = 1'b0;
    model_clear();
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Impulse through ramp coefficients, back to back, also checking the issue period.
  task automatic test_impulse();
    int prev;
    load_ramp_coefs();
    do_flush();
    for (int i = 0; i < NTAPS; i++) begin
      send(i == 0 ? 16'h7FFF : 16'h0000);
      if (i > 0) begin
        checks++;
        if (last_acc - prev !== NTAPS + 2) begin
          errors++;
          $display("FAIL throughput: accept spacing %0d expected %0d", last_acc - prev, NTAPS + 2);
        end
      end
      prev = last_acc;
    end
    drain();
  endtask

  task automatic test_latency();
    int n = 0;
    logic [15:0] held;
    out_ready = 1'b1;
    send(16'h1234);
    while (!out_valid && n < 50) begin step(); n++; end
    checks++;
    if (n !== NTAPS) begin errors++; $display("FAIL latency: %0d cycles expected %0d", n, NTAPS); end
    drain();

    out_ready = 1'b0;
    send(16'h0100);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
      if (out_data !== held)  begin errors++; $display("FAIL stall_data: got %h expected %h", out_data, held); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    end
    out_ready = 1'b1;
    drain();
  endtask

  // Coefficient write attempted while busy must not land.
  task automatic test_coef_guard();
    do_flush();
    send(16'h7FFF);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL guard_busy: got %b expected 1", busy); end
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF;
    repeat (2) step();
    coef_we = 1'b0;
    drain();
    do_flush();
    send(16'h7FFF);
    drain();
  endtask

  // Simultaneous coef write and flush both apply; in_ready drops meanwhile.
  task automatic test_flush();
    send(16'h3000);
    send(16'h5000);
    drain();
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h4000; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_in_ready: got %b expected 0", in_ready); end
    step();
    coef_we = 1'b0; flush = 1'b0;
    m_coef[0] = 16'h4000;
    for (int i = 0; i < NTAPS; i++) m_hist[i] = '0;
    m_wr = 0;
    for (int k = 1; k < NTAPS; k++) write_coef(k, 16'h1000);
    send(16'h4000);
    drain();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h7FFF);
    do_flush();
    for (int i = 0; i < NTAPS; i++) send(16'h7FFF);
    drain();
  endtask

  task automatic test_reset_mid_mac();
    load_ramp_coefs();
    do_flush();
    send(16'h7FFF);
    repeat (3) step();
    system1000_rst = 1'b1;
    model_clear();
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    repeat (2) step();
    system1000_rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < NTAPS + 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost: got out_valid %b expected 0", out_valid); end
    end
    load_ramp_coefs();
    for (int i = 0; i < NTAPS; i++) send(i == 0 ? 16'h7FFF : 16'h0000);
    drain();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_coef_guard();
    test_flush();
    test_overflow();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
